alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter WIDTH, 8, datapath and register width in bits.
REQ-002 Parameter NREG, 8, register-file depth; address width is clog2(NREG) = 3.
REQ-003 Parameter DIV_CYCLES, 4, number of EXEC cycles spent on opcode 7 (DIV).
REQ-004 clock  in  1  single clock; all state changes on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  operation request.
REQ-007 req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid & req_ready.
REQ-008 req_op  in  4  ALU opcode: 0 OR, 1 AND, 2 NOT, 3 ADD, 4 SUB, 5 NEG, 7 DIV, 8 SHL, 9 SHR, 11 ROL, 12 ROR.
REQ-009 req_ra, req_rb, req_rd  in  3 each  source A, source B and destination register indices.
REQ-010 wr_en, wr_addr[2:0], wr_data[7:0]  in  host register preload port.
REQ-011 dbg_addr  in  3; dbg_data  out  8  combinational register-file read.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  high for exactly the one WB cycle of each operation.
REQ-014 err  out  1  valid only while done is high.
REQ-015 result  out  8  current Z register contents.

Function
REQ-016 The FSM SHALL have states IDLE, READ, EXEC and WB.
REQ-017 IDLE->READ on accept; captured op/ra/rb/rd are held in internal registers for the whole operation.
REQ-018 READ (1 cycle): Y <= R[ra]; then ->EXEC.
REQ-019 EXEC: the ALU is driven with (Y, R[rb], op); Z <= ALU result at the last EXEC edge; EXEC lasts 1 cycle, or DIV_CYCLES cycles for op 7; then ->WB.
REQ-020 WB (1 cycle): done=1; on the closing edge R[rd] <= Z unless err; then ->IDLE.
REQ-021 Latency: done is high in the 3rd cycle after the accept edge (DIV: cycle 2+DIV_CYCLES); minimum request spacing is 4 cycles (DIV: 3+DIV_CYCLES).
REQ-022 Opcodes 6, 10, 13, 14 and 15 are illegal: the full sequence still runs, err=1 in WB, and no register is written.
REQ-023 DIV with R[rb]=0 SHALL load Z=8'hFF, set err=1 in WB and suppress writeback.
REQ-024 Arithmetic is modulo 2^WIDTH; shift and rotate amounts use R[rb][2:0].
REQ-025 wr_en takes effect only in IDLE and is ignored otherwise.
REQ-026 wr_en together with an accept on the same edge: the write completes first, and READ sees the new value.
REQ-027 rd equal to ra or rb is legal; the sources are consumed before writeback.
REQ-028 req_valid outside IDLE is ignored; it is neither queued nor flagged.

Reset
REQ-029 resetn low SHALL immediately force state=IDLE and clear all registers R0-R7, Y, Z and the captured fields to 0, including mid-operation; the aborted operation is discarded and produces no done or write.
REQ-030 While resetn is low: req_ready=0, busy=0, done=0, err=0, result=0.
REQ-031 On the first edge after reset release, req_ready=1.

Structure
REQ-032 A shared package alu_seq_pkg SHALL hold the opcode constants, the illegal-opcode predicate and the state enum {IDLE, READ, EXEC, WB}.
REQ-033 The block SHALL instantiate the existing combinational 8-bit ALU module as its one sub-module; the register file, Y/Z registers, DIV cycle counter and FSM are local logic.

Verification
REQ-034 Preload R1=20, R2=5; ADD ra=1 rb=2 rd=3 -> done in the 3rd cycle after accept, err=0, result=25, then dbg R3=25.
REQ-035 Same operands with DIV -> done in cycle 6, result=4, R3=4; req_ready stays 0 throughout.
REQ-036 Preload R4=8'hB2, R5=2; run SHL, SHR, ROL, ROR into R6 -> 8'hC8, 8'h2C, 8'hCA, 8'hAC.
REQ-037 op=6, and DIV with R2=0 -> done with err=1 and rd unchanged; Z=8'hFF for the divide case.
REQ-038 wr_en R1=7 on the same edge as accept of NOT ra=1 rd=0 -> R0=8'hF8; wr_en asserted while busy -> no change.
REQ-039 Assert resetn low during EXEC of a DIV -> no done pulse, all registers 0, req_ready=1 on the first edge after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, illegal-opcode predicate and FSM state encoding
// for the ALU operation sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_OR  = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_NEG = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'd6) || (op == 4'd10) || (op >= 4'd13);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// Combinational ALU: a is the Y operand, b the R[rb] operand.
// err flags illegal opcodes and divide by zero (which yields all ones).
module alu_op_sequencer_alu
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  logic [2:0]         sh;
  logic [2*WIDTH-1:0] dbl;

  assign sh  = b[2:0];
  assign dbl = {a, a};

  always_comb begin
    y   = '0;
    err = is_illegal(op);
    case (op)
      OP_OR:  y = a | b;
      OP_AND: y = a & b;
      OP_NOT: y = ~a;
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_NEG: y = -a;
      OP_DIV: begin
        if (b == '0) begin
          y   = '1;
          err = 1'b1;
        end else begin
          y = a / b;
        end
      end
      OP_SHL: y = a << sh;
      OP_SHR: y = a >> sh;
      // Rotates pick a WIDTH-bit window out of {a, a}.
      OP_ROL: y = dbl[2*WIDTH-1-int'(sh) -: WIDTH];
      OP_ROR: y = dbl[WIDTH-1+int'(sh) -: WIDTH];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Register-file ALU sequencer: IDLE -> READ (Y <= R[ra]) -> EXEC (Z <= ALU)
// -> WB (R[rd] <= Z unless err). DIV stays in EXEC for DIV_CYCLES cycles.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NREG       = 8,
  parameter int DIV_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_op,
  input  logic [$clog2(NREG)-1:0] req_ra,
  input  logic [$clog2(NREG)-1:0] req_rb,
  input  logic [$clog2(NREG)-1:0] req_rd,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [WIDTH-1:0]        dbg_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [WIDTH-1:0]        result
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

  state_t            state_reg, state_next;
  logic              run_reg;
  logic [3:0]        op_reg;
  logic [AW-1:0]     ra_reg, rb_reg, rd_reg;
  logic [WIDTH-1:0]  y_reg, z_reg;
  logic              err_reg;
  logic [CW-1:0]     cnt_reg;
  logic [WIDTH-1:0]  regs [NREG];
  logic [WIDTH-1:0]  alu_y;
  logic              alu_err;
  logic              accept, exec_last, host_wr, wb_wr;

  // run_reg keeps req_ready low while reset is held and until the first edge after release.
  assign req_ready = run_reg && (state_reg == IDLE);
  assign accept    = req_valid && req_ready;
  assign exec_last = (op_reg != OP_DIV) || (cnt_reg == CNT_LAST);
  assign host_wr   = wr_en && (state_reg == IDLE);
  assign wb_wr     = (state_reg == WB) && !err_reg;

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == WB);
  assign err      = (state_reg == WB) && err_reg;
  assign result   = z_reg;
  assign dbg_data = regs[dbg_addr];

  alu_op_sequencer_alu #(.WIDTH(WIDTH)) u_alu (
    .a   (y_reg),
    .b   (regs[rb_reg]),
    .op  (op_reg),
    .y   (alu_y),
    .err (alu_err)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    if (exec_last) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_reg  <= '0;
      ra_reg  <= '0;
      rb_reg  <= '0;
      rd_reg  <= '0;
      y_reg   <= '0;
      z_reg   <= '0;
      err_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg <= req_op;
            ra_reg <= req_ra;
            rb_reg <= req_rb;
            rd_reg <= req_rd;
          end
        end
        READ: begin
          y_reg   <= regs[ra_reg];
          cnt_reg <= '0;
        end
        EXEC: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (exec_last) begin
            z_reg   <= alu_y;
            err_reg <= alu_err;
          end
        end
        default: ;
      endcase
    end
  end

  // Host writes and writeback never coincide: one is IDLE-only, the other WB-only.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
        regs[gi] <= '0;
      else if (host_wr && (wr_addr == AW'(gi)))
        regs[gi] <= wr_data;
      else if (wb_wr && (rd_reg == AW'(gi)))
        regs[gi] <= z_reg;
    end
  end

endmodule
